load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Byte-addressed load/store front end sitting directly upstream of the 64-bit word data memory.
- Accepts one core request at a time on a valid/ready handshake.
- Converts byte/half/word/dword accesses into word-granular memory reads and writes. Sub-word stores use read-modify-write.
- Returns aligned, sign- or zero-extended load data, and flags misaligned or reserved-word accesses.

Parameters:
- BITSIZE, 64, data width. Fixed at 64; the byte-lane logic depends on it.
- MEMSIZE, 64, number of memory words. Word address width is $clog2(MEMSIZE).
- RESERVED_WORD, MEMSIZE-1, word address the memory never reads or writes. Any access to it is an error.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword
- req_signed  in  1  sign-extend the load result (ignored for dword and for stores)
- req_addr  in  $clog2(MEMSIZE)+3  byte address
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  error flag, valid while resp_valid is high
- resp_rdata  out  64  load result; 0 for stores and on error
- mem_addr  out  $clog2(MEMSIZE)  word address, equal to req_addr[MSB:3]
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  combinational memory read data

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- mem_we and mem_re are decoded from state only. Asynchronous reset therefore drops them immediately, mid-operation included.
- req_ready=1 only in IDLE. A request is accepted on a rising edge with req_valid & req_ready. All request fields are registered at acceptance.
- Error check at acceptance:
  - Misaligned: size 1 with addr[0]≠0; size 2 with addr[1:0]≠0; size 3 with addr[2:0]≠0.
  - Reserved: word address equal to RESERVED_WORD.
  - On error: next state is RESP with err=1 and rdata=0. mem_re and mem_we are never asserted for the request.
- States:
  - IDLE: wait for an accepted request, then go to ACCESS, or to RESP on error.
  - ACCESS:
    - Load: mem_re=1. At the edge, capture the extracted result into resp_rdata, then go to RESP.
    - Dword store: mem_we=1, mem_wdata=req_wdata, then go to RESP.
    - Sub-word store: mem_re=1. At the edge, capture mem_rdata into the merge register, then go to WRITE.
  - WRITE (sub-word stores only): mem_we=1, mem_wdata=merged word, then go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE. There is no response back-pressure.
- Latency from the accept edge to the resp_valid cycle:
  - Error: 1 cycle.
  - Load and dword store: 2 cycles.
  - Sub-word store: 3 cycles.
- Byte lanes are little-endian, with offset = addr[2:0].
- Load extraction: take mem_rdata >> (8*offset), mask to the access size, then sign-extend from the top bit of the size if req_signed, otherwise zero-extend.
- Store merge: replace bytes offset..offset+nbytes-1 of the read word with the low bytes of req_wdata. All other bytes are preserved.
- mem_addr holds the registered word address in ACCESS and WRITE, and is 0 otherwise.
- A new request is never accepted in the RESP cycle. The earliest back-to-back accept is the cycle after resp_valid.

Decomposition:
- Shared package lsu_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD.
  - State enum IDLE, ACCESS, WRITE, RESP.
  - BITSIZE and MEMSIZE constants.
- Sub-module lsu_lane_align: purely combinational extract and merge functions (offset, size, signed → result/merged word). The FSM stays in the top module.

Test Plan:
1. Memory reset to 0. Store dword 0x1122334455667788 at addr 0x010 → mem_we for one cycle with mem_addr=2. Then load dword at 0x010 → resp_rdata=0x1122334455667788, with resp_valid 2 cycles after accept.
2. Store byte 0xAB at 0x013 → mem_re cycle, then mem_we with mem_wdata=0x11223344AB667788, then resp_valid (3 cycles). Load byte signed at 0x013 → 0xFFFFFFFFFFFFFFAB. Load byte unsigned at 0x013 → 0x00000000000000AB.
3. Load half signed at 0x016 → 0x0000000000001122. Store half 0x8001 at 0x016, then load half signed at 0x016 → 0xFFFFFFFFFFFF8001.
4. Load word at 0x012 (misaligned) → resp_valid 1 cycle after accept, resp_err=1, resp_rdata=0, mem_re and mem_we never high.
5. Store dword at 0x1F8 (word 63) → resp_err=1, mem_we never high. A subsequent load at 0x010 returns the unchanged value.
6. Assert rst during the ACCESS cycle of a sub-word store → mem_we never pulses, resp_valid stays 0, req_ready=1 immediately, and the target word in memory is unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// and the alignment rule used at request acceptance.
package lsu_pkg;

    localparam int BITSIZE = 64;
    localparam int MEMSIZE = 64;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // An access is aligned when the low log2(nbytes) offset bits are zero.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            SZ_HALF:  return offset[0];
            SZ_WORD:  return |offset[1:0];
            SZ_DWORD: return |offset;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [BITSIZE-1:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 64'h0000_0000_0000_00FF;
            SZ_HALF: return 64'h0000_0000_0000_FFFF;
            SZ_WORD: return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane steering: extracts a sign/zero-extended load value from a
// memory word, and merges sub-word store data into a previously read word.
module lsu_lane_align (
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [63:0] rdata,
    input  logic [63:0] base,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] merged
);
    import lsu_pkg::*;

    function automatic logic [63:0] extract(input logic [63:0] word, input logic [2:0] off,
                                            input logic [1:0] sz, input logic sgn);
        logic [63:0] sh;
        sh = word >> {off, 3'b000};
        case (sz)
            SZ_BYTE: return sgn ? 64'($signed(sh[7:0]))  : 64'(sh[7:0]);
            SZ_HALF: return sgn ? 64'($signed(sh[15:0])) : 64'(sh[15:0]);
            SZ_WORD: return sgn ? 64'($signed(sh[31:0])) : 64'(sh[31:0]);
            default: return sh;
        endcase
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_word, input logic [63:0] data,
                                          input logic [2:0] off, input logic [1:0] sz);
        logic [63:0] lanes;
        lanes = size_mask(sz) << {off, 3'b000};
        return (old_word & ~lanes) | ((data << {off, 3'b000}) & lanes);
    endfunction

    assign load_data = extract(rdata, offset, size, sign);
    assign merged    = merge(base, wdata, offset, size);

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a 64-bit word memory; sub-word stores are
// done as read-modify-write, and misaligned or reserved-word accesses return an error.
module load_store_unit #(
    parameter int BITSIZE       = lsu_pkg::BITSIZE,
    parameter int MEMSIZE       = lsu_pkg::MEMSIZE,
    parameter int RESERVED_WORD = MEMSIZE - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [1:0]                   req_size,
    input  logic                         req_signed,
    input  logic [$clog2(MEMSIZE)+2:0]   req_addr,
    input  logic [BITSIZE-1:0]           req_wdata,
    output logic                         resp_valid,
    output logic                         resp_err,
    output logic [BITSIZE-1:0]           resp_rdata,
    output logic [$clog2(MEMSIZE)-1:0]   mem_addr,
    output logic                         mem_we,
    output logic                         mem_re,
    output logic [BITSIZE-1:0]           mem_wdata,
    input  logic [BITSIZE-1:0]           mem_rdata
);
    import lsu_pkg::*;

    localparam int WA = $clog2(MEMSIZE);
    localparam int AW = WA + 3;

    state_t             state, state_next;
    logic               write_q;
    logic [1:0]         size_q;
    logic               sign_q;
    logic [2:0]         offset_q;
    logic [WA-1:0]      waddr_q;
    logic [BITSIZE-1:0] wdata_q;
    logic [BITSIZE-1:0] merge_q;
    logic [BITSIZE-1:0] load_data;
    logic [BITSIZE-1:0] merged;
    logic               accept;
    logic               req_err;
    logic               dword_store;

    assign accept      = req_valid && (state == IDLE);
    assign req_err     = misaligned(req_size, req_addr[2:0]) ||
                         (req_addr[AW-1:3] == WA'(RESERVED_WORD));
    assign dword_store = write_q && (size_q == SZ_DWORD);

    lsu_lane_align u_align (
        .offset    (offset_q),
        .size      (size_q),
        .sign      (sign_q),
        .rdata     (mem_rdata),
        .base      (merge_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory strobes depend only on state and registered request fields, so an
    // asynchronous reset removes them immediately.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = waddr_q;
                if (dword_store) begin
                    mem_we     = 1'b1;
                    mem_wdata  = wdata_q;
                    state_next = RESP;
                end else begin
                    mem_re     = 1'b1;
                    state_next = write_q ? WRITE : RESP;
                end
            end
            WRITE: begin
                mem_addr   = waddr_q;
                mem_we     = 1'b1;
                mem_wdata  = merged;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            sign_q     <= 1'b0;
            offset_q   <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                write_q    <= req_write;
                size_q     <= req_size;
                sign_q     <= req_signed;
                offset_q   <= req_addr[2:0];
                waddr_q    <= req_addr[AW-1:3];
                wdata_q    <= req_wdata;
                resp_err   <= req_err;
                resp_rdata <= '0;
            end
            if (state == ACCESS) begin
                if (!write_q) begin
                    resp_rdata <= load_data;
                end else if (!dword_store) begin
                    merge_q <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    logic [63:0] mem [0:63] = '{default: 64'h0};
    logic [7:0]  ref_bytes [0:511] = '{default: 8'h0};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input int w);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_bytes[8*w + i];
        return v;
    endfunction

    function automatic logic [63:0] ref_load(input int a, input int n, input logic sg);
        logic [63:0] v = '0;
        logic [63:0] ones = '1;
        for (int i = 0; i < n; i++) v = v | (64'(ref_bytes[a + i]) << (8*i));
        if (sg && n < 8 && v[8*n - 1]) v = v | (ones << (8*n));
        return v;
    endfunction

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [8:0] ad, input logic [63:0] wd, output logic [63:0] got);
        int n = 1 << sz;
        int a = int'(ad);
        logic err = ((a % n) != 0) || (ad[8:3] == 6'd63);
        logic [63:0] exp_rd = (!wr && !err) ? ref_load(a, n, sg) : 64'h0;
        int exp_lat = err ? 1 : ((wr && sz != 2'd3) ? 3 : 2);
        int exp_re  = (err || (wr && sz == 2'd3)) ? 0 : 1;
        int exp_we  = (err || !wr) ? 0 : 1;
        int lat = 0, re_n = 0, we_n = 0;
        logic got_err = 1'bx;
        logic [5:0]  we_addr = '0;
        logic [63:0] we_data = '0;
        got = 'x;
        @(negedge clk);
        check("ready_before_accept", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_re) re_n++;
            if (mem_we) begin we_n++; we_addr = mem_addr; we_data = mem_wdata; end
            if (resp_valid) begin
                lat = c; got_err = resp_err; got = resp_rdata;
                break;
            end
            @(negedge clk);
        end
        if (wr && !err)
            for (int i = 0; i < n; i++) ref_bytes[a + i] = wd[8*i +: 8];
        check("latency", 64'(lat), 64'(exp_lat));
        check("resp_err", 64'(got_err), 64'(err));
        check("resp_rdata", got, exp_rd);
        check("mem_re_cycles", 64'(re_n), 64'(exp_re));
        check("mem_we_cycles", 64'(we_n), 64'(exp_we));
        if (exp_we == 1) begin
            check("mem_we_addr", 64'(we_addr), 64'(ad[8:3]));
            check("mem_we_data", we_data, ref_word(int'(ad[8:3])));
        end
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] saved;
        logic [1:0]  sz;
        logic [8:0]  ad;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_re", 64'(mem_re), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        rst = 1'b0;

        do_req(1'b1, 2'd3, 1'b0, 9'h010, 64'h1122334455667788, got);
        do_req(1'b0, 2'd3, 1'b0, 9'h010, 64'h0, got);
        check("p1_load_dword", got, 64'h1122334455667788);

        do_req(1'b1, 2'd0, 1'b0, 9'h013, 64'h00000000000000AB, got);
        check("p2_mem_word2", mem[2], 64'h11223344AB667788);
        do_req(1'b0, 2'd0, 1'b1, 9'h013, 64'h0, got);
        check("p2_load_byte_s", got, 64'hFFFFFFFFFFFFFFAB);
        do_req(1'b0, 2'd0, 1'b0, 9'h013, 64'h0, got);
        check("p2_load_byte_u", got, 64'h00000000000000AB);

        do_req(1'b0, 2'd1, 1'b1, 9'h016, 64'h0, got);
        check("p3_load_half_s", got, 64'h0000000000001122);
        do_req(1'b1, 2'd1, 1'b0, 9'h016, 64'h0000000000008001, got);
        do_req(1'b0, 2'd1, 1'b1, 9'h016, 64'h0, got);
        check("p3_load_half_neg", got, 64'hFFFFFFFFFFFF8001);

        do_req(1'b0, 2'd2, 1'b0, 9'h012, 64'h0, got);
        do_req(1'b1, 2'd3, 1'b0, 9'h1F8, 64'hDEADBEEFDEADBEEF, got);
        check("p5_word63_untouched", mem[63], 64'h0);
        do_req(1'b0, 2'd3, 1'b0, 9'h010, 64'h0, got);
        check("p5_word2_unchanged", got, 64'h80013344AB667788);

        for (int k = 0; k < 60; k++) begin
            sz = 2'($urandom_range(0, 3));
            ad = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 7) != 0) ad = ad & ~(9'((1 << sz) - 1));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad,
                   {$urandom, $urandom}, got);
        end

        saved = mem[4];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 9'h021; req_wdata = 64'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        check("p6_access_re", 64'(mem_re), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("p6_rst_we", 64'(mem_we), 64'd0);
        check("p6_rst_re", 64'(mem_re), 64'd0);
        check("p6_rst_ready", 64'(req_ready), 64'd1);
        check("p6_rst_valid", 64'(resp_valid), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("p6_hold_we", 64'(mem_we), 64'd0);
            check("p6_hold_valid", 64'(resp_valid), 64'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("p6_post_we", 64'(mem_we), 64'd0);
            check("p6_post_valid", 64'(resp_valid), 64'd0);
        end
        check("p6_word_unchanged", mem[4], saved);
        check("p6_word_model", mem[4], ref_word(4));
        do_req(1'b0, 2'd3, 1'b0, 9'h020, 64'h0, got);

        for (int w = 0; w < 64; w++) check("final_mem", mem[w], ref_word(w));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
